// File: rtl/register_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc_rf_pkg
// Description : Shared types, default widths and a field-slicing helper for
//               the multi-port register file.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package tc_rf_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  localparam int TC_DATA_W = 8;
  localparam int TC_ADDR_W = 2;

  // Widest packed per-port vector and widest single field the helper handles
  localparam int TC_VEC_MAX   = 256;
  localparam int TC_FIELD_MAX = 32;

  // Extract field idx of the given width from a packed per-port vector
  function automatic logic [TC_FIELD_MAX-1:0] field_slice(
    input logic [TC_VEC_MAX-1:0] vec,
    input int                    idx,
    input int                    width
  );
    logic [TC_VEC_MAX-1:0] w_shifted;
    w_shifted = vec >> (idx * width);
    return w_shifted[TC_FIELD_MAX-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_if
// Description : Read, write and clear-control bundle of the register file.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface register_file_mp_if
  import tc_rf_pkg::*;
#(
  parameter int DATA_W = TC_DATA_W,
  parameter int ADDR_W = TC_ADDR_W,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_drop;
  logic                     clr_req;
  logic                     busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data, rd_valid, wr_drop, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
    output rd_data, rd_valid, wr_drop, busy
  );
endinterface
`default_nettype wire

// File: rtl/register_file_mp_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : rf_clear_seq
// Description : Bulk-clear sequencer. Walks a pointer over every entry, one
//               per cycle, issuing a zero-write and holding busy meanwhile.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module rf_clear_seq
  import tc_rf_pkg::*;
#(
  parameter int ADDR_W = TC_ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clr_req,
  output logic                   clr_we,
  output logic [ADDR_W-1:0]      clr_addr,
  output logic                   busy
);

  localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;

  // State and pointer registers; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: start on clr_req in IDLE, leave after the last entry
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == c_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign busy     = (r_state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Multi-read-port register file with registered reads,
//               write-first bypass, optional hardwired-zero entry 0 and a
//               bulk-clear sequencer.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module register_file_mp
  import tc_rf_pkg::*;
#(
  parameter int DATA_W  = TC_DATA_W,
  parameter int ADDR_W  = TC_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  register_file_mp_if.slave  bus
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        r_mem [c_DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD*DATA_W-1:0] w_rd_data_nxt;
  logic [NUM_RD-1:0]        r_rd_valid;
  logic                     r_wr_drop;
  logic [ADDR_W-1:0]        w_rd_addr [NUM_RD];

  logic                     w_clr_we;
  logic [ADDR_W-1:0]        w_clr_addr;
  logic                     w_busy;
  logic                     w_wr_acc;
  logic                     w_wr_store;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (bus.clr_req),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .busy     (w_busy)
  );

  // A user write is taken only while the sequencer is idle; entry 0 may be
  // hardwired so its writes are accepted but never land in the array.
  assign w_wr_acc   = bus.wr_en && !w_busy;
  assign w_wr_store = w_wr_acc && !((R0_ZERO != 0) && (bus.wr_addr == '0));

  // Storage array: clear-sequencer zero-write or accepted user write
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < c_DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else begin
      if (w_clr_we) begin
        r_mem[w_clr_addr] <= '0;
      end
      if (w_wr_store) begin
        r_mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Unpack the per-port read addresses
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_addr[i] = ADDR_W'(field_slice(TC_VEC_MAX'(bus.rd_addr), i, ADDR_W));
    end
  end

  // Next read data per port: hardwired zero, then write bypass, then the
  // entry being cleared this cycle, then the array itself
  always_comb begin
    w_rd_data_nxt = r_rd_data;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_en[i]) begin
        if ((R0_ZERO != 0) && (w_rd_addr[i] == '0)) begin
          w_rd_data_nxt[i*DATA_W +: DATA_W] = '0;
        end else if (w_wr_acc && (w_rd_addr[i] == bus.wr_addr)) begin
          w_rd_data_nxt[i*DATA_W +: DATA_W] = bus.wr_data;
        end else if (w_clr_we && (w_rd_addr[i] == w_clr_addr)) begin
          w_rd_data_nxt[i*DATA_W +: DATA_W] = '0;
        end else begin
          w_rd_data_nxt[i*DATA_W +: DATA_W] = r_mem[w_rd_addr[i]];
        end
      end
    end
  end

  // Read data/valid registers and the dropped-write flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= bus.rd_en;
      r_wr_drop  <= bus.wr_en && w_busy;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.wr_drop  = r_wr_drop;
  assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the 4x8 register file in the TinyChip datapath.
- Configurable data width, depth and number of read ports.
- Registered, posedge-sampled reads with a read-valid strobe and same-cycle write-to-read bypass.
- Optional hardwired-zero register 0, plus a multi-cycle bulk-clear sequencer so software can zero the file without a global reset.

Parameters:
- DATA_W, 8: bits per register.
- ADDR_W, 2: address bits; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent read ports.
- R0_ZERO, 0: when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  one clock; reset is synchronous and active-low.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  port i data at bits [i*DATA_W +: DATA_W], registered.
- rd_valid  out  NUM_RD  1-cycle strobe: rd_data for port i updated this cycle.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_drop  out  1  registered pulse: last cycle's wr_en was discarded because busy.
- clr_req  in  1  start bulk clear (level sampled; acted on in IDLE only).
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (reset==0 at posedge):
  - all entries = 0
  - rd_data = 0, rd_valid = 0, wr_drop = 0, busy = 0
  - FSM = IDLE, clear pointer = 0
  - reset overrides every other input in that cycle, including mid-clear (sequence aborts; the array is zeroed anyway).
- Write: in IDLE, wr_en at posedge t stores wr_data at wr_addr; visible to array reads from t+1.
- Read latency is 1 cycle:
  - rd_en[i] at posedge t -> rd_data[i] = value at rd_addr[i] and rd_valid[i] = 1 after t.
  - rd_en[i] low -> rd_data[i] holds its previous value, rd_valid[i] = 0.
- Bypass (write-first): if wr_en is accepted in the same cycle as rd_en[i] with rd_addr[i] == wr_addr, rd_data[i] = wr_data. This applies independently per port, so all ports may bypass simultaneously.
- R0_ZERO=1:
  - writes to address 0 are silently ignored (wr_drop stays 0).
  - reads of address 0 return 0, including under bypass.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr_req==1 at posedge. busy = 1 from the next cycle; pointer starts at 0.
  - CLEAR: each cycle writes 0 to entry[pointer], then pointer += 1.
  - CLEAR -> IDLE: on the cycle that clears entry DEPTH-1. busy falls after that edge, so busy is high for exactly DEPTH cycles and the pointer wraps to 0.
  - A clr_req held high on return to IDLE starts a new sequence (back-to-back allowed).
  - clr_req while in CLEAR is ignored and not queued.
- During CLEAR:
  - wr_en is discarded; wr_drop = 1 on the following cycle.
  - A write on the same edge as IDLE->CLEAR is accepted, because the state is still IDLE.
  - Reads remain serviced: an entry not yet cleared returns its old value; an entry already cleared, or being cleared this cycle (rd_addr == pointer), returns 0.
- Arithmetic: pointer is ADDR_W bits and wraps naturally. No other arithmetic in the block.
- Multiple read ports may hit the same address with no conflict. Reads never stall.

Decomposition:
- Package tc_rf_pkg:
  - state enum rf_state_t {IDLE, CLEAR}
  - default-parameter constants TC_DATA_W = 8, TC_ADDR_W = 2
  - function for slicing packed per-port address/data fields
- Sub-module rf_clear_seq:
  - contains the FSM, pointer and busy logic
  - outputs clr_we, clr_addr and busy
- Top level: the array, write mux (user write vs clear), per-port read/bypass registers and wr_drop.

Test Plan:
- Reset then read: hold reset=0 two cycles, release; rd_en=2'b11, addr 0 and 3 -> rd_data both 0x00, rd_valid=2'b11 next cycle.
- Write/read with bypass: write 0xA5 to reg 2 with port0 reading reg 2 the same cycle -> port0 0xA5 next cycle; port1 reads reg 2 a cycle later -> 0xA5.
- Dual port plus R0_ZERO=1: write 0x3C to reg 0 and 0x77 to reg 1 -> port0 reads reg 0 = 0x00, port1 reads reg 1 = 0x77, wr_drop never asserts.
- Bulk clear: fill regs 0..3 with 0x11..0x44, pulse clr_req:
  - busy high for exactly 4 cycles
  - a write issued in the second busy cycle -> wr_drop pulse, value not stored
  - afterwards all reads return 0x00
- Read during clear: in the first busy cycle (pointer=0), read reg 3 -> 0x44 and read reg 0 -> 0x00.
- Reset mid-clear (DATA_W=16, ADDR_W=3): assert reset at the third busy cycle -> busy=0 next cycle, all 8 entries read 0x0000, FSM accepts a new clr_req immediately.
